// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length helper for the
// per-slave arbiter.
package ahb_slave_arbiter_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HBURST encodings
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Ownership tracking state of one slave port
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN   = 2'b01,
    BURST = 2'b10
  } arb_state_e;

  // Number of beats in a burst; 0 means undefined length (INCR)
  function automatic logic [4:0] burst_beats(input logic [2:0] hb);
    logic [4:0] beats;
    case (hb)
      HBURST_SINGLE:                beats = 5'd1;
      HBURST_INCR:                  beats = 5'd0;
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above rr_ptr,
// wrapping modulo CHANNEL_NUM. Produces a one-hot grant and its index.
module ahb_rr_picker
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int CHANNEL_NUM = 4,
  parameter int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic [CHANNEL_NUM-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [CHANNEL_NUM-1:0] gnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  // Scan the request vector starting at rr_ptr and keep the first hit
  always_comb begin : pick
    int               pos_v;
    logic [IDX_W-1:0] cand_v;
    gnt    = '0;
    idx    = '0;
    valid  = 1'b0;
    pos_v  = 0;
    cand_v = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      pos_v = int'(rr_ptr) + i;
      if (pos_v >= CHANNEL_NUM) begin
        pos_v = pos_v - CHANNEL_NUM;
      end else begin
        pos_v = pos_v;
      end
      cand_v = IDX_W'(pos_v);
      if (!valid && req[cand_v]) begin
        valid       = 1'b1;
        idx         = cand_v;
        gnt[cand_v] = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave arbiter: owns one slave port on behalf of one master channel,
// follows bursts and locked sequences, and drives the address-phase and
// data-phase one-hot selects for that slave's muxes.
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int CHANNEL_NUM = 4,
  parameter int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [CHANNEL_NUM-1:0]   req,
  input  logic [CHANNEL_NUM*2-1:0] htrans,
  input  logic [CHANNEL_NUM*3-1:0] hburst,
  input  logic [CHANNEL_NUM-1:0]   hmastlock,
  input  logic                     hready,
  output logic [CHANNEL_NUM-1:0]   sel_addr,
  output logic [CHANNEL_NUM-1:0]   sel_data,
  output logic [IDX_W-1:0]         hmaster,
  output logic                     owned
);

  arb_state_e             state_q,    state_d;
  logic [CHANNEL_NUM-1:0] sel_addr_q, sel_addr_d;
  logic [CHANNEL_NUM-1:0] sel_data_q, sel_data_d;
  logic [IDX_W-1:0]       hmaster_q,  hmaster_d;
  logic                   owned_q,    owned_d;
  logic [IDX_W-1:0]       rr_ptr_q,   rr_ptr_d;
  logic [3:0]             beat_cnt_q, beat_cnt_d;

  logic [CHANNEL_NUM-1:0] win_gnt_s;
  logic [IDX_W-1:0]       win_idx_s;
  logic                   win_valid_s;
  logic [IDX_W-1:0]       win_next_s;

  logic [1:0]             own_trans_s;
  logic [2:0]             own_burst_s;
  logic                   own_lock_s;
  logic                   own_req_s;
  logic [4:0]             own_beats_s;
  logic                   release_s;

  ahb_rr_picker #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (win_gnt_s),
    .idx    (win_idx_s),
    .valid  (win_valid_s)
  );

  // Pointer value after granting the current winner (wraps at CHANNEL_NUM)
  always_comb begin
    if (win_idx_s == IDX_W'(CHANNEL_NUM - 1)) begin
      win_next_s = '0;
    end else begin
      win_next_s = win_idx_s + IDX_W'(1);
    end
  end

  // Pick out the current owner's transfer attributes from the packed buses
  always_comb begin
    own_trans_s = 2'b00;
    own_burst_s = 3'b000;
    own_lock_s  = 1'b0;
    own_req_s   = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (hmaster_q == IDX_W'(i)) begin
        own_trans_s = htrans[i*2 +: 2];
        own_burst_s = hburst[i*3 +: 3];
        own_lock_s  = hmastlock[i];
        own_req_s   = req[i];
      end else begin
        own_req_s = own_req_s;
      end
    end
    own_beats_s = burst_beats(own_burst_s);
  end

  // Ownership FSM: everything advances only on accepted transfers
  always_comb begin
    state_d    = state_q;
    sel_addr_d = sel_addr_q;
    sel_data_d = sel_data_q;
    hmaster_d  = hmaster_q;
    owned_d    = owned_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    release_s  = 1'b0;

    if (hready) begin
      sel_data_d = sel_addr_q;
      case (state_q)
        IDLE: begin
          // From IDLE a grant behaves exactly like a release with no owner
          release_s = 1'b1;
        end
        OWN: begin
          if (own_lock_s) begin
            state_d = OWN;
          end else if (!own_req_s || (own_trans_s == HTRANS_IDLE)) begin
            release_s = 1'b1;
          end else if (own_trans_s == HTRANS_NONSEQ) begin
            if (own_beats_s == 5'd1) begin
              release_s = 1'b1;
            end else if (own_beats_s == 5'd0) begin
              state_d = OWN;
            end else begin
              beat_cnt_d = 4'(own_beats_s - 5'd1);
              state_d    = BURST;
            end
          end else begin
            // SEQ/BUSY of an undefined-length burst: hold while requested
            state_d = OWN;
          end
        end
        BURST: begin
          if (own_trans_s == HTRANS_SEQ) begin
            if (beat_cnt_q <= 4'd1) begin
              beat_cnt_d = 4'd0;
              if (own_lock_s) begin
                state_d = OWN;
              end else begin
                release_s = 1'b1;
              end
            end else begin
              beat_cnt_d = beat_cnt_q - 4'd1;
            end
          end else if (own_trans_s == HTRANS_BUSY) begin
            beat_cnt_d = beat_cnt_q;
          end else begin
            // IDLE or NONSEQ before the count runs out ends the burst early
            beat_cnt_d = 4'd0;
            if (own_lock_s) begin
              state_d = OWN;
            end else begin
              release_s = 1'b1;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          sel_addr_d = '0;
          hmaster_d  = '0;
          owned_d    = 1'b0;
          beat_cnt_d = 4'd0;
        end
      endcase

      // Release either hands over back-to-back or parks the port in IDLE
      if (release_s) begin
        beat_cnt_d = 4'd0;
        if (win_valid_s) begin
          state_d    = OWN;
          sel_addr_d = win_gnt_s;
          hmaster_d  = win_idx_s;
          owned_d    = 1'b1;
          rr_ptr_d   = win_next_s;
        end else begin
          state_d    = IDLE;
          sel_addr_d = '0;
          hmaster_d  = '0;
          owned_d    = 1'b0;
        end
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      sel_data_d = sel_data_q;
    end
  end

  // State and select registers with asynchronous clear
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= IDLE;
      sel_addr_q <= '0;
      sel_data_q <= '0;
      hmaster_q  <= '0;
      owned_q    <= 1'b0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      sel_addr_q <= sel_addr_d;
      sel_data_q <= sel_data_d;
      hmaster_q  <= hmaster_d;
      owned_q    <= owned_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign sel_addr = sel_addr_q;
  assign sel_data = sel_data_q;
  assign hmaster  = hmaster_q;
  assign owned    = owned_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter with CHANNEL_NUM=4.
module tb_ahb_slave_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_WRAP8  = 3'b100;
  localparam logic [2:0] B_INCR16 = 3'b111;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [3:0]  req;
  logic [7:0]  htrans;
  logic [11:0] hburst;
  logic [3:0]  hmastlock;
  logic        hready;
  logic [3:0]  sel_addr;
  logic [3:0]  sel_data;
  logic [1:0]  hmaster;
  logic        owned;

  int total = 0;
  int bad   = 0;

  ahb_slave_arbiter #(.CHANNEL_NUM(4)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .req       (req),
    .htrans    (htrans),
    .hburst    (hburst),
    .hmastlock (hmastlock),
    .hready    (hready),
    .sel_addr  (sel_addr),
    .sel_data  (sel_data),
    .hmaster   (hmaster),
    .owned     (owned)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] sa, input logic [3:0] sd,
                     input logic [1:0] hm);
    check({tag, ".sel_addr"}, {28'd0, sel_addr}, {28'd0, sa});
    check({tag, ".sel_data"}, {28'd0, sel_data}, {28'd0, sd});
    check({tag, ".hmaster"},  {30'd0, hmaster},  {30'd0, hm});
    check({tag, ".owned"},    {31'd0, owned},    {31'd0, |sa});
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_m(input int m, input logic [1:0] t, input logic [2:0] b);
    htrans[m*2 +: 2] = t;
    hburst[m*3 +: 3] = b;
  endtask

  task automatic do_reset();
    req       = 4'b0000;
    htrans    = 8'h00;
    hburst    = 12'h000;
    hmastlock = 4'b0000;
    hready    = 1'b1;
    hresetn   = 1'b0;
    tick();
    hresetn   = 1'b1;
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    // ---------------- reset state
    do_reset();
    chk("rst", 4'b0000, 4'b0000, 2'd0);

    // ---------------- single master, SINGLE NONSEQ
    req = 4'b0100;
    tick();
    chk("t1.grant", 4'b0100, 4'b0000, 2'd2);
    set_m(2, T_NSEQ, B_SINGLE);
    hready = 1'b0;
    tick();
    chk("t1.wait1", 4'b0100, 4'b0000, 2'd2);
    tick();
    chk("t1.wait2", 4'b0100, 4'b0000, 2'd2);
    hready = 1'b1;
    tick();
    // SINGLE accepted with req still high: released and re-granted to 2
    chk("t1.beat", 4'b0100, 4'b0100, 2'd2);
    req = 4'b0000;
    set_m(2, T_IDLE, B_SINGLE);
    tick();
    chk("t1.rel", 4'b0000, 4'b0100, 2'd0);
    tick();
    chk("t1.idle", 4'b0000, 4'b0000, 2'd0);

    // ---------------- all request, SINGLE back-to-back round robin
    do_reset();
    req = 4'b1111;
    for (int m = 0; m < 4; m++) set_m(m, T_NSEQ, B_SINGLE);
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    tick();
    chk("t2.g0", rr_exp[0], 4'b0000, 2'd0);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk($sformatf("t2.g%0d", k), rr_exp[k], rr_exp[k-1], 2'(k % 4));
    end

    // ---------------- INCR4 on master 1 with waits and BUSY, master 3 waiting
    do_reset();
    req = 4'b1010;
    tick();
    chk("t3.grant", 4'b0010, 4'b0000, 2'd1);
    set_m(1, T_NSEQ, B_INCR4);
    tick();
    chk("t3.nseq", 4'b0010, 4'b0010, 2'd1);
    set_m(1, T_SEQ, B_INCR4);
    hready = 1'b0;
    tick();
    chk("t3.ws1", 4'b0010, 4'b0010, 2'd1);
    tick();
    chk("t3.ws2", 4'b0010, 4'b0010, 2'd1);
    hready = 1'b1;
    tick();
    chk("t3.seq1", 4'b0010, 4'b0010, 2'd1);
    set_m(1, T_BUSY, B_INCR4);
    tick();
    chk("t3.busy", 4'b0010, 4'b0010, 2'd1);
    set_m(1, T_SEQ, B_INCR4);
    tick();
    chk("t3.seq2", 4'b0010, 4'b0010, 2'd1);
    tick();
    chk("t3.seq3", 4'b1000, 4'b0010, 2'd3);
    req = 4'b1000;
    set_m(1, T_IDLE, B_SINGLE);
    set_m(3, T_NSEQ, B_INCR);
    tick();
    chk("t3.m3", 4'b1000, 4'b1000, 2'd3);

    // ---------------- locked INCR on master 0, master 1 waiting
    do_reset();
    req = 4'b0011;
    hmastlock = 4'b0001;
    tick();
    chk("t4.grant", 4'b0001, 4'b0000, 2'd0);
    set_m(0, T_NSEQ, B_INCR);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t4.lk%0d", k), 4'b0001, 4'b0001, 2'd0);
      set_m(0, T_SEQ, B_INCR);
    end
    hmastlock = 4'b0000;
    tick();
    chk("t4.unlock", 4'b0001, 4'b0001, 2'd0);
    set_m(0, T_IDLE, B_INCR);
    tick();
    chk("t4.rel", 4'b0010, 4'b0001, 2'd1);

    // ---------------- WRAP8 terminated early by IDLE
    do_reset();
    req = 4'b0011;
    tick();
    chk("t5.grant", 4'b0001, 4'b0000, 2'd0);
    set_m(0, T_NSEQ, B_WRAP8);
    tick();
    chk("t5.b1", 4'b0001, 4'b0001, 2'd0);
    set_m(0, T_SEQ, B_WRAP8);
    tick();
    chk("t5.b2", 4'b0001, 4'b0001, 2'd0);
    tick();
    chk("t5.b3", 4'b0001, 4'b0001, 2'd0);
    set_m(0, T_IDLE, B_WRAP8);
    tick();
    chk("t5.term", 4'b0010, 4'b0001, 2'd1);

    // ---------------- asynchronous reset during INCR16
    do_reset();
    req = 4'b1111;
    tick();
    chk("t6.grant", 4'b0001, 4'b0000, 2'd0);
    set_m(0, T_NSEQ, B_INCR16);
    tick();
    set_m(0, T_SEQ, B_INCR16);
    tick();
    chk("t6.b2", 4'b0001, 4'b0001, 2'd0);
    #2;
    hresetn = 1'b0;
    #1;
    chk("t6.async", 4'b0000, 4'b0000, 2'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    set_m(0, T_IDLE, B_SINGLE);
    tick();
    chk("t6.after", 4'b0001, 4'b0000, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
